// File: rtl/vga_axi_rd_arbiter_pkg.sv
// Shared types and constants for the VGA frame-memory read arbiter.
// Holds the arbiter state encoding, AXI response codes and requester indices.
package vga_axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic REQ_DISP = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/vga_axi_rd_arbiter_starve_ctr.sv
// Saturating wait counter for the auxiliary requester.
// o_limit flags that the aux port has waited long enough to override display priority.
module vga_starve_ctr #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_limit
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] r_cnt;

    // Clear wins over increment so the acceptance cycle always restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_limit = (r_cnt == LIM);

endmodule

// File: rtl/vga_axi_rd_arbiter.sv
// Two-requester AXI4-Lite read arbiter: display has fixed priority, aux is
// protected by a starvation counter; one transaction outstanding at a time.
module vga_axi_rd_arbiter
    import vga_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [AXI_ADDR_WIDTH-1:0] d_araddr_i,
    input  logic [2:0]                d_arprot_i,
    input  logic                      d_arvalid_i,
    output logic                      d_arrdy_o,
    output logic [AXI_DATA_WIDTH-1:0] d_rdata_o,
    output logic [1:0]                d_rresp_o,
    output logic                      d_rvalid_o,
    input  logic                      d_rrdy_i,

    input  logic [AXI_ADDR_WIDTH-1:0] a_araddr_i,
    input  logic [2:0]                a_arprot_i,
    input  logic                      a_arvalid_i,
    output logic                      a_arrdy_o,
    output logic [AXI_DATA_WIDTH-1:0] a_rdata_o,
    output logic [1:0]                a_rresp_o,
    output logic                      a_rvalid_o,
    input  logic                      a_rrdy_i,

    output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
    output logic [2:0]                m_arprot_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arrdy_i,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rrdy_o,

    output logic                      grant_o,
    output logic                      err_o
);

    arb_state_t                r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [2:0]                r_arprot;
    logic                      r_arvalid;
    logic                      r_grant;
    logic                      r_err;

    logic w_idle;
    logic w_in_data;
    logic w_any;
    logic w_starved;
    logic w_sel_aux;
    logic w_d_acc;
    logic w_a_acc;
    logic w_rrdy_sel;
    logic w_rd_done;
    logic w_to_disp;
    logic w_to_aux;

    // rst_n gates acceptance so arrdy reads zero while reset is held.
    assign w_idle    = (r_state == IDLE) && rst_n;
    assign w_in_data = (r_state == DATA);
    assign w_any     = d_arvalid_i || a_arvalid_i;
    assign w_sel_aux = a_arvalid_i && (!d_arvalid_i || w_starved);
    assign w_d_acc   = w_idle && d_arvalid_i && !w_sel_aux;
    assign w_a_acc   = w_idle && w_sel_aux;

    vga_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (a_arvalid_i && !w_a_acc),
        .i_clr   (w_a_acc),
        .o_limit (w_starved)
    );

    assign w_rrdy_sel = (r_grant == REQ_AUX) ? a_rrdy_i : d_rrdy_i;
    assign w_rd_done  = w_in_data && m_rvalid_i && w_rrdy_sel;
    assign w_to_disp  = w_in_data && (r_grant == REQ_DISP);
    assign w_to_aux   = w_in_data && (r_grant == REQ_AUX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_araddr  <= '0;
            r_arprot  <= '0;
            r_arvalid <= 1'b0;
            r_grant   <= REQ_DISP;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_sel_aux ? REQ_AUX : REQ_DISP;
                        r_araddr  <= w_sel_aux ? a_araddr_i : d_araddr_i;
                        r_arprot  <= w_sel_aux ? a_arprot_i : d_arprot_i;
                        r_arvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (r_arvalid && m_arrdy_i) begin
                        r_arvalid <= 1'b0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_rd_done) begin
                        if (resp_is_err(m_rresp_i)) begin
                            r_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign d_arrdy_o   = w_d_acc;
    assign a_arrdy_o   = w_a_acc;

    assign m_araddr_o  = r_araddr;
    assign m_arprot_o  = r_arprot;
    assign m_arvalid_o = r_arvalid;
    assign m_rrdy_o    = w_in_data && w_rrdy_sel;

    assign d_rvalid_o  = w_to_disp && m_rvalid_i;
    assign d_rdata_o   = w_to_disp ? m_rdata_i : '0;
    assign d_rresp_o   = w_to_disp ? m_rresp_i : '0;

    assign a_rvalid_o  = w_to_aux && m_rvalid_i;
    assign a_rdata_o   = w_to_aux ? m_rdata_i : '0;
    assign a_rresp_o   = w_to_aux ? m_rresp_i : '0;

    assign grant_o     = r_grant;
    assign err_o       = r_err;

endmodule

// File: tb/tb_vga_axi_rd_arbiter.sv
// Bench for vga_axi_rd_arbiter: directed scenarios plus random traffic, all
// outputs compared each cycle against a transaction-level reference model.
module tb_vga_axi_rd_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] d_araddr, a_araddr, m_araddr;
    logic [2:0]    d_arprot, a_arprot, m_arprot;
    logic          d_arvalid, a_arvalid, d_arrdy, a_arrdy;
    logic [DW-1:0] d_rdata, a_rdata, m_rdata;
    logic [1:0]    d_rresp, a_rresp, m_rresp;
    logic          d_rvalid, a_rvalid, d_rrdy, a_rrdy;
    logic          m_arvalid, m_arrdy, m_rvalid, m_rrdy;
    logic          grant, err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    vga_axi_rd_arbiter #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_araddr_i  (d_araddr),
        .d_arprot_i  (d_arprot),
        .d_arvalid_i (d_arvalid),
        .d_arrdy_o   (d_arrdy),
        .d_rdata_o   (d_rdata),
        .d_rresp_o   (d_rresp),
        .d_rvalid_o  (d_rvalid),
        .d_rrdy_i    (d_rrdy),
        .a_araddr_i  (a_araddr),
        .a_arprot_i  (a_arprot),
        .a_arvalid_i (a_arvalid),
        .a_arrdy_o   (a_arrdy),
        .a_rdata_o   (a_rdata),
        .a_rresp_o   (a_rresp),
        .a_rvalid_o  (a_rvalid),
        .a_rrdy_i    (a_rrdy),
        .m_araddr_o  (m_araddr),
        .m_arprot_o  (m_arprot),
        .m_arvalid_o (m_arvalid),
        .m_arrdy_i   (m_arrdy),
        .m_rdata_i   (m_rdata),
        .m_rresp_i   (m_rresp),
        .m_rvalid_i  (m_rvalid),
        .m_rrdy_o    (m_rrdy),
        .grant_o     (grant),
        .err_o       (err)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction phase (0 free, 1 address pending, 2 awaiting data),
    // owner and captured request, sticky error, and how long aux has been waiting.
    int            md_phase = 0;
    logic          md_owner = 1'b0;
    logic [AW-1:0] md_addr  = '0;
    logic [2:0]    md_prot  = '0;
    logic          md_err   = 1'b0;
    int            md_wait  = 0;

    always @(negedge clk) begin
        logic aux_wins, any, acc_d, acc_a, own_rrdy, to_d, to_a;
        if (!rst_n) begin
            check_eq("reset_outs",
                     {d_arrdy, a_arrdy, d_rvalid, a_rvalid, m_arvalid, m_rrdy, grant, err},
                     8'h00);
            check_eq("reset_addr", {m_araddr, m_arprot}, '0);
            md_phase = 0; md_owner = 1'b0; md_addr = '0; md_prot = '0;
            md_err = 1'b0; md_wait = 0;
        end else begin
            any      = d_arvalid || a_arvalid;
            aux_wins = a_arvalid && (!d_arvalid || md_wait >= int'(LIMIT));
            acc_a    = (md_phase == 0) && aux_wins;
            acc_d    = (md_phase == 0) && any && !aux_wins;
            own_rrdy = md_owner ? a_rrdy : d_rrdy;
            to_d     = (md_phase == 2) && !md_owner;
            to_a     = (md_phase == 2) && md_owner;

            check_eq("d_arrdy", d_arrdy, acc_d);
            check_eq("a_arrdy", a_arrdy, acc_a);
            check_eq("m_arvalid", m_arvalid, md_phase == 1);
            check_eq("m_araddr", {m_arprot, m_araddr}, {md_prot, md_addr});
            check_eq("m_rrdy", m_rrdy, (md_phase == 2) && own_rrdy);
            check_eq("d_r", {d_rvalid, d_rresp, d_rdata},
                     to_d ? {m_rvalid, m_rresp, m_rdata} : '0);
            check_eq("a_r", {a_rvalid, a_rresp, a_rdata},
                     to_a ? {m_rvalid, m_rresp, m_rdata} : '0);
            check_eq("grant", grant, md_owner);
            check_eq("err", err, md_err);

            if (acc_a) md_wait = 0;
            else if (a_arvalid && md_wait < int'(LIMIT)) md_wait++;

            case (md_phase)
                0: if (any) begin
                    md_owner = aux_wins;
                    md_addr  = aux_wins ? a_araddr : d_araddr;
                    md_prot  = aux_wins ? a_arprot : d_arprot;
                    md_phase = 1;
                end
                1: if (m_arrdy) md_phase = 2;
                default: if (m_rvalid && own_rrdy) begin
                    if (m_rresp != 2'b00) md_err = 1'b1;
                    md_phase = 0;
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        d_arvalid = 0; a_arvalid = 0; d_araddr = '0; a_araddr = '0;
        d_arprot = '0; a_arprot = '0; d_rrdy = 0; a_rrdy = 0;
        m_arrdy = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 0;
        quiet_inputs();
        cyc(); cyc();
        rst_n = 1;
    endtask

    initial begin
        quiet_inputs();
        #1;
        do_reset();

        // Display only: address accepted, 2 cycles of downstream stall, data 0xA5.
        d_arvalid = 1; d_araddr = 32'h100; d_arprot = 3'd2;
        cyc();
        d_arvalid = 0;
        check_eq("disp_addr", m_araddr, 32'h100);
        check_eq("disp_arvalid", m_arvalid, 1'b1);
        cyc(); cyc();
        m_arrdy = 1;
        cyc();
        m_arrdy = 0; m_rvalid = 1; m_rdata = 64'hA5; d_rrdy = 1;
        #1;
        check_eq("disp_rdata", d_rdata, 64'hA5);
        check_eq("disp_grant", grant, 1'b0);
        cyc();
        quiet_inputs();
        cyc();

        // Simultaneous requests: display first, aux next.
        d_arvalid = 1; d_araddr = 32'h10; a_arvalid = 1; a_araddr = 32'h20;
        m_arrdy = 1; m_rvalid = 1; d_rrdy = 1; a_rrdy = 1; m_rdata = 64'h1234;
        cyc();
        d_arvalid = 0;
        check_eq("sim_first", m_araddr, 32'h10);
        cyc(); cyc(); cyc();
        check_eq("sim_second", m_araddr, 32'h20);
        check_eq("sim_grant", grant, 1'b1);
        a_arvalid = 0;
        cyc(); cyc();
        quiet_inputs();

        // Backpressure: data held off by d_rrdy for 5 cycles.
        d_arvalid = 1; d_araddr = 32'h200; m_arrdy = 1;
        cyc();
        d_arvalid = 0;
        cyc();
        m_arrdy = 0; m_rvalid = 1; m_rdata = 64'hBEEF; d_rrdy = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_rrdy_low", m_rrdy, 1'b0);
            cyc();
        end
        d_rrdy = 1;
        #1;
        check_eq("bp_rrdy_high", m_rrdy, 1'b1);
        cyc();
        quiet_inputs();
        cyc();

        // Starvation: both requesters held high with a zero-wait downstream.
        do_reset();
        d_arvalid = 1; d_araddr = 32'h40; a_arvalid = 1; a_araddr = 32'h80;
        m_arrdy = 1; m_rvalid = 1; d_rrdy = 1; a_rrdy = 1;
        repeat (9) cyc();
        check_eq("starve_aux_wins", {a_arrdy, d_arrdy}, 2'b10);
        repeat (3) cyc();
        check_eq("starve_cleared", {a_arrdy, d_arrdy}, 2'b01);
        check_eq("starve_grant_aux", grant, 1'b1);
        quiet_inputs();
        cyc(); cyc(); cyc();

        // Reset while the address phase is pending.
        d_arvalid = 1; d_araddr = 32'h300;
        cyc();
        d_arvalid = 0;
        check_eq("rst_pre_arvalid", m_arvalid, 1'b1);
        rst_n = 0;
        #1;
        check_eq("rst_arvalid_now", m_arvalid, 1'b0);
        cyc(); cyc();
        rst_n = 1;
        d_arvalid = 1; d_araddr = 32'h500; m_arrdy = 1; m_rvalid = 1; d_rrdy = 1;
        m_rdata = 64'h55;
        cyc();
        d_arvalid = 0;
        cyc();
        check_eq("rst_new_rvalid", d_rvalid, 1'b1);
        cyc();
        quiet_inputs();

        // Random traffic with OKAY responses.
        for (int i = 0; i < 3000; i++) begin
            d_arvalid = ($urandom_range(9) < 7);
            a_arvalid = ($urandom_range(1) == 1);
            d_araddr  = $urandom;
            a_araddr  = $urandom;
            d_arprot  = 3'($urandom);
            a_arprot  = 3'($urandom);
            m_arrdy   = ($urandom_range(1) == 1);
            m_rvalid  = ($urandom_range(1) == 1);
            m_rdata   = {$urandom, $urandom};
            d_rrdy    = ($urandom_range(3) != 0);
            a_rrdy    = ($urandom_range(3) != 0);
            cyc();
        end
        quiet_inputs();
        repeat (3) cyc();

        // Error response on an aux read sets a sticky err_o.
        a_arvalid = 1; a_araddr = 32'h600; m_arrdy = 1;
        cyc();
        a_arvalid = 0;
        cyc();
        m_rvalid = 1; m_rresp = 2'b10; a_rrdy = 1; m_rdata = 64'h77;
        #1;
        check_eq("err_rresp", a_rresp, 2'b10);
        cyc();
        check_eq("err_set", err, 1'b1);
        m_rvalid = 0; m_rresp = 2'b00;
        a_arvalid = 1; a_araddr = 32'h608;
        cyc();
        a_arvalid = 0;
        cyc();
        m_rvalid = 1;
        cyc();
        m_rvalid = 0;
        check_eq("err_sticky", err, 1'b1);
        rst_n = 0;
        #1;
        check_eq("err_cleared", err, 1'b0);
        cyc();
        rst_n = 1;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_axi_rd_arbiter.md
# vga_axi_rd_arbiter

Two-requester AXI4-Lite read-channel arbiter between the VGA frame fetcher (`vga_axi_mem_ctrl`) and an auxiliary requester (debug/CPU port) on one shared downstream read bus to frame memory. The display requester has fixed priority. The auxiliary requester is protected by a starvation counter. One transaction is outstanding at a time, and the read address is buffered inside the arbiter.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, address width on all ports
- AXI_DATA_WIDTH, 64, read data width on all ports
- STARVE_LIMIT, 8, number of cycles the aux request may wait before it overrides display priority (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- d_araddr_i / a_araddr_i  in  AXI_ADDR_WIDTH  requester read address (display / aux)
- d_arprot_i / a_arprot_i  in  3  requester protection bits
- d_arvalid_i / a_arvalid_i  in  1  requester address valid
- d_arrdy_o / a_arrdy_o  out  1  address accept to requester
- d_rdata_o / a_rdata_o  out  AXI_DATA_WIDTH  routed read data
- d_rresp_o / a_rresp_o  out  2  routed read response
- d_rvalid_o / a_rvalid_o  out  1  routed read valid
- d_rrdy_i / a_rrdy_i  in  1  requester read ready
- m_araddr_o  out  AXI_ADDR_WIDTH  downstream address, registered
- m_arprot_o  out  3  downstream protection, registered
- m_arvalid_o  out  1  downstream address valid
- m_arrdy_i  in  1  downstream address ready
- m_rdata_i  in  AXI_DATA_WIDTH  downstream read data
- m_rresp_i  in  2  downstream read response
- m_rvalid_i  in  1  downstream read valid
- m_rrdy_o  out  1  downstream read ready
- grant_o  out  1  current owner: 0 = display, 1 = aux; held stable outside IDLE
- err_o  out  1  sticky flag, set by any completed read with rresp ≠ OKAY (2'b00); cleared only by reset

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE:**
  - If any arvalid is high, select the winner.
  - Display wins unless the aux starvation count has reached STARVE_LIMIT, in which case aux wins.
  - If only one requester is valid, it wins.
  - The winner's arrdy is driven high combinationally in the same cycle.
  - Address and prot are registered into m_araddr_o/m_arprot_o, grant_o is registered, and the FSM moves to ADDR.
- **ADDR:**
  - m_arvalid_o = 1.
  - On m_arvalid_o & m_arrdy_i, go to DATA.
  - Address and prot stay stable until the handshake.
- **DATA:**
  - m_rrdy_o = rrdy of the granted requester.
  - The granted requester's rvalid = m_rvalid_i; its rdata/rresp = m_rdata_i/m_rresp_i.
  - On m_rvalid_i & m_rrdy_o, go to IDLE and update err_o.
- **Non-granted requester:** arrdy = 0 and rvalid = 0 at all times; its rdata/rresp are driven '0.
- **Starvation counter:**
  - Increments each cycle that a_arvalid_i = 1 and aux is not being accepted.
  - Saturates at STARVE_LIMIT.
  - Cleared in the cycle aux is accepted.
  - Width is $clog2(STARVE_LIMIT+1).

## Timing
- **Reset values:**
  - state = IDLE; m_arvalid_o, m_rrdy_o, all arrdy/rvalid outputs = 0.
  - m_araddr_o = '0, m_arprot_o = '0, grant_o = 0, err_o = 0, starvation counter = 0.
- **Handshake latency:**
  - Request accepted in cycle k → m_arvalid_o high from cycle k+1.
  - Data handshake in cycle j → next request can be accepted in cycle j+1.
  - Minimum transaction is 3 cycles (IDLE, ADDR, DATA).
- **Simultaneous requests in IDLE:** display is granted unless the counter equals STARVE_LIMIT.
- **Requester drops arvalid before acceptance:** no effect. Only IDLE samples arvalid.
- **rresp routing:** combinational pass-through in DATA. No extra register stage.
- **Reset mid-transaction:** all outputs return to reset values immediately. The downstream transaction is abandoned; frame memory must tolerate this.

## Structure
- Shared package `vga_axi_pkg` holds:
  - the state enum `arb_state_t` {IDLE, ADDR, DATA};
  - `AXI_RESP_OKAY` = 2'b00 and `AXI_RESP_SLVERR` = 2'b10;
  - the requester index constants `REQ_DISP` = 0 and `REQ_AUX` = 1.
- One sub-module, `vga_starve_ctr`: saturating counter with inputs inc/clr and a limit-reached output.
- FSM and routing stay in the top module.

## Test plan
- **Display only:** d_arvalid_i with d_araddr_i = 0x100, downstream ready after 2 cycles, rdata 0xA5 → m_araddr_o = 0x100, d_rdata_o = 0xA5, grant_o = 0, a_rvalid_o never high.
- **Simultaneous requests:** both valid, d_araddr_i = 0x10, a_araddr_i = 0x20 → first m_araddr_o = 0x10, the second transaction carries 0x20.
- **Starvation:** display valid continuously, aux valid continuously, STARVE_LIMIT = 8 → aux is granted at the first IDLE after its counter reaches 8, and the counter then reads 0.
- **Backpressure:** d_rrdy_i held low for 5 cycles while m_rvalid_i = 1 → m_rrdy_o = 0 for those cycles, state stays DATA, completion on the first d_rrdy_i = 1.
- **Error flag:** m_rresp_i = 2'b10 on the aux read → a_rresp_o = 2'b10 and err_o = 1; err_o stays set through later OKAY reads until rst_n is asserted.
- **Reset mid-operation:** assert rst_n = 0 during ADDR → m_arvalid_o = 0 immediately, state = IDLE after release, and a new request completes normally.
